// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, colour widths and a counter-width helper
// shared by the VGA timing generator and its axis counters.
package vga_pkg;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_R_W      = 3;
    localparam int DEF_G_W      = 3;
    localparam int DEF_B_W      = 2;

    // Bits needed to hold 0..total-1; never less than one bit.
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 on enable and decodes the active and sync
// regions (order: active, front porch, sync, back porch).
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL  = 800,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter bit POL    = 1'b0,
    parameter int W      = cnt_width(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    // One extra bit so a sync region ending exactly at TOTAL still fits.
    localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_BEG = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_END = (W+1)'(ACTIVE + FP + SYNC);

    logic [W:0] count_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

    always_comb begin
        count_x = {1'b0, count};
        wrap    = (count == LAST);
        active  = (count_x < ACT_END);
        sync    = ((count_x >= SYNC_BEG) && (count_x < SYNC_END)) ? POL : ~POL;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, h/v axis counters,
// coordinate request (stage 0) and registered sync/colour pin stage (stage 1).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int R_W      = DEF_R_W,
    parameter int G_W      = DEF_G_W,
    parameter int B_W      = DEF_B_W,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int CW_H    = cnt_width(H_TOTAL),
    localparam int CW_V    = cnt_width(V_TOTAL),
    localparam int C_W     = R_W + G_W + B_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [C_W-1:0]  color,
    output logic [CW_H-1:0] x_ptr,
    output logic [CW_V-1:0] y_ptr,
    output logic            req_valid,
    output logic            pix_tick,
    output logic            hsync,
    output logic            vsync,
    output logic [R_W-1:0]  VGA_R,
    output logic [G_W-1:0]  VGA_G,
    output logic [B_W-1:0]  VGA_B,
    output logic            frame_start,
    output logic            line_start
);

    localparam int                DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [CW_H-1:0]  h;
    logic [CW_V-1:0]  v;
    logic             h_wrap, h_active, h_sync;
    logic             v_active, v_sync;

    // The divider only produces an enable; everything stays on clk.
    always_ff @(posedge clk) begin
        if (reset || pix_tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign pix_tick = (div == DIV_LAST);

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .ACTIVE(H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .POL   (HS_POL),
        .W     (CW_H)
    ) u_h (
        .clk   (clk),
        .reset (reset),
        .en    (pix_tick),
        .count (h),
        .wrap  (h_wrap),
        .active(h_active),
        .sync  (h_sync)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .ACTIVE(V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .POL   (VS_POL),
        .W     (CW_V)
    ) u_v (
        .clk   (clk),
        .reset (reset),
        .en    (pix_tick && h_wrap),
        .count (v),
        .wrap  (),
        .active(v_active),
        .sync  (v_sync)
    );

    // req_valid qualifies x_ptr/y_ptr for the whole pixel period; there is no
    // ready: the colour source must answer by the pix_tick that ends the period.
    always_comb begin
        req_valid   = h_active && v_active;
        x_ptr       = req_valid ? h : '0;
        y_ptr       = req_valid ? v : '0;
        line_start  = pix_tick && (h == '0);
        frame_start = line_start && (v == '0);
    end

    // Sync and colour share one register stage so the pins stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            {VGA_R, VGA_G, VGA_B} <= '0;
        end else if (pix_tick) begin
            hsync <= h_sync;
            vsync <= v_sync;
            {VGA_R, VGA_G, VGA_B} <= req_valid ? color : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small mode: random colour/reset stimulus, a
// tick-index reference model and a scoreboard for the registered pin stage.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int CLK_DIV = 3;
    localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
    localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
    localparam bit HP = 1'b1, VP = 1'b0;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int CWH = cnt_width(HT);
    localparam int CWV = cnt_width(VT);
    localparam int CW  = 8;
    localparam int FRAME_CLKS = HT * VT * CLK_DIV;
    localparam logic [CW+1:0] RESET_OUT = {~HP, ~VP, 8'h00};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [CW-1:0] color = '0;
    always #5 clk = ~clk;

    logic [CWH-1:0] x_ptr;
    logic [CWV-1:0] y_ptr;
    logic req_valid, pix_tick, hsync, vsync, frame_start, line_start;
    logic [2:0] vga_r;
    logic [2:0] vga_g;
    logic [1:0] vga_b;

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP),
        .R_W(3), .G_W(3), .B_W(2)
    ) dut (
        .clk(clk), .reset(reset), .color(color),
        .x_ptr(x_ptr), .y_ptr(y_ptr), .req_valid(req_valid),
        .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .frame_start(frame_start), .line_start(line_start)
    );

    // ---------------- reference model ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [CW+1:0] exp_q[$];
    int m_cyc = 0;      // clocks since the last reset edge
    int m_k = 0;        // pixel ticks taken since the last reset edge
    bit model_ok = 1'b0;
    bit pushed = 1'b0;
    bit win_en = 1'b0;
    int fs_cnt = 0;
    int ls_cnt = 0;

    function automatic int mh(input int k);
        return k % HT;
    endfunction

    function automatic int mv(input int k);
        return (k / HT) % VT;
    endfunction

    function automatic logic [CW+1:0] pins_for(input int k, input logic [CW-1:0] c);
        int h, v;
        logic hs, vs;
        logic [CW-1:0] rgb;
        h = mh(k);
        v = mv(k);
        hs = (h >= HA + HF && h < HA + HF + HSW) ? HP : ~HP;
        vs = (v >= VA + VF && v < VA + VF + VSW) ? VP : ~VP;
        rgb = (h < HA && v < VA) ? c : 8'h00;
        return {hs, vs, rgb};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit rst);
        @(posedge clk);
        if (reset) begin
            m_cyc = 0;
            m_k = 0;
        end else begin
            if (m_cyc % CLK_DIV == CLK_DIV - 1) m_k++;
            m_cyc++;
        end
        model_ok = 1'b1;
        #1;
        reset = rst;
        pushed = 1'b0;
        if (m_cyc % CLK_DIV == CLK_DIV - 1) begin
            color = {3'(mh(m_k)), 3'(mv(m_k)), 2'b01};
            if (!rst) begin
                exp_q.push_back(pins_for(m_k, color));
                pushed = 1'b1;
            end
        end else begin
            color = 8'($urandom);
        end
    endtask

    // ---------------- monitor ----------------
    logic rst_q = 1'b1;
    always @(posedge clk) rst_q <= reset;

    always @(negedge clk) begin : mon
        int h, v, since_rel;
        bit act, exp_tick, tick_prev, wait_tick;
        logic [CW+1:0] held;
        if (model_ok) begin
            exp_tick = (m_cyc % CLK_DIV == CLK_DIV - 1);
            h = mh(m_k);
            v = mv(m_k);
            act = (h < HA) && (v < VA);
            check("pix_tick", pix_tick, exp_tick);
            check("req_valid", req_valid, act);
            check("x_ptr", x_ptr, act ? h : 0);
            check("y_ptr", y_ptr, act ? v : 0);
            check("line_start", line_start, exp_tick && h == 0);
            check("frame_start", frame_start, exp_tick && h == 0 && v == 0);

            if (rst_q) begin
                held = RESET_OUT;
            end else if (tick_prev) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    held = exp_q.pop_front();
                end
            end
            check("pins_hs_vs_rgb", {hsync, vsync, vga_r, vga_g, vga_b}, held);
            tick_prev = pix_tick;

            if (rst_q) begin
                since_rel = 1;
                wait_tick = 1'b1;
            end else begin
                since_rel++;
            end
            if (wait_tick && !reset && (pix_tick || since_rel > CLK_DIV)) begin
                check("first_tick_latency", since_rel, CLK_DIV);
                wait_tick = 1'b0;
            end

            if (win_en) begin
                fs_cnt += int'(frame_start);
                ls_cnt += int'(line_start);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) cycle(1'b1);
        cycle(1'b0);
        win_en = 1'b1;
        repeat (2 * FRAME_CLKS) cycle(1'b0);
        win_en = 1'b0;
        check("frame_start_count_2_frames", fs_cnt, 2);
        check("line_start_count_2_frames", ls_cnt, 2 * VT);

        // Mid-frame resets held for 3 clocks at random points.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(20, 150)) cycle(1'b0);
            repeat (3) cycle(1'b1);
        end
        repeat (FRAME_CLKS + FRAME_CLKS / 2) cycle(1'b0);

        do cycle(1'b0); while (pushed);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
